// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the RV32IM ALU decode-and-execute unit:
//   alu_op_e  - internal operation code produced by the decoder
//   state_e   - IDLE/BUSY control state of the execute unit
//   F3_*/F7_* - instruction funct3 / funct7 field codes
//   ALUOP_*   - alu_op encodings from main control
//   is_muldiv / is_divrem - operation class helpers
// ---------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [4:0] {
        OP_ADD,
        OP_SUB,
        OP_SLL,
        OP_SLT,
        OP_SLTU,
        OP_XOR,
        OP_SRL,
        OP_SRA,
        OP_OR,
        OP_AND,
        OP_MUL,
        OP_MULH,
        OP_MULHSU,
        OP_MULHU,
        OP_DIV,
        OP_DIVU,
        OP_REM,
        OP_REMU,
        OP_ILLEGAL
    } alu_op_e;

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    // Base / M-extension funct3 codes
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [2:0] F3_MUL     = 3'b000;
    localparam logic [2:0] F3_MULH    = 3'b001;
    localparam logic [2:0] F3_MULHSU  = 3'b010;
    localparam logic [2:0] F3_MULHU   = 3'b011;
    localparam logic [2:0] F3_DIV     = 3'b100;
    localparam logic [2:0] F3_DIVU    = 3'b101;
    localparam logic [2:0] F3_REM     = 3'b110;
    localparam logic [2:0] F3_REMU    = 3'b111;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_ITYPE = 2'b10;
    localparam logic [1:0] ALUOP_RTYPE = 2'b11;

    function automatic logic is_divrem(input alu_op_e op);
        case (op)
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

    function automatic logic is_muldiv(input alu_op_e op);
        case (op)
            OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: return 1'b1;
            default:                              return is_divrem(op);
        endcase
    endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// ---------------------------------------------------------------------------
// alu_iter_muldiv
// XLEN-iteration multiply/divide engine working on operand magnitudes.
//   clk, rst, flush : clock, synchronous reset, abort
//   start           : load operands and begin (one-cycle pulse)
//   op              : OP_MUL..OP_REMU
//   a, b            : operands (a = multiplier / dividend, b = multiplicand / divisor)
//   done            : high in the cycle whose rising edge performs the last
//                     iteration; result is valid alongside it
//   result          : sign-corrected result of the final iteration
// Division by zero and signed overflow are handled by the caller and never
// started here.
// ---------------------------------------------------------------------------
module alu_iter_muldiv
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            start,
    input  alu_op_e         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CNT_W = $clog2(XLEN);

    logic                 busy_q;
    logic [CNT_W-1:0]     cnt_q;
    alu_op_e              op_q;
    logic                 neg_q;
    logic [XLEN-1:0]      mcand_q;
    logic [2*XLEN-1:0]    acc_q;
    logic [2*XLEN-1:0]    acc_nxt;
    logic [2*XLEN-1:0]    prod_fix;
    logic [XLEN:0]        sum;
    logic [XLEN:0]        trial;
    logic [XLEN-1:0]      quo;
    logic [XLEN-1:0]      rem;

    logic                 a_sgn;
    logic                 b_sgn;
    logic                 a_neg;
    logic                 b_neg;
    logic [XLEN-1:0]      a_mag;
    logic [XLEN-1:0]      b_mag;

    // Operand signedness per op; magnitudes of negative signed operands.
    always_comb begin
        a_sgn = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
                (op == OP_DIV) || (op == OP_REM);
        b_sgn = (op == OP_MUL) || (op == OP_MULH) ||
                (op == OP_DIV) || (op == OP_REM);
        a_neg = a_sgn && a[XLEN-1];
        b_neg = b_sgn && b[XLEN-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end

    // One iteration. Multiply: shift-add with the carry captured in the top
    // bit. Divide: acc holds {remainder, quotient}; shift left one and
    // restore-subtract the divisor.
    always_comb begin
        acc_nxt = acc_q;
        sum     = '0;
        trial   = '0;
        if (is_divrem(op_q)) begin
            trial = acc_q[2*XLEN-1:XLEN-1];
            if (trial >= {1'b0, mcand_q}) begin
                acc_nxt = {trial[XLEN-1:0] - mcand_q, acc_q[XLEN-2:0], 1'b1};
            end else begin
                acc_nxt = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            end
        end else begin
            sum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mcand_q & {XLEN{acc_q[0]}}};
            acc_nxt = {sum, acc_q[XLEN-1:1]};
        end
    end

    // Sign fix-up on the value being handed out with done.
    always_comb begin
        prod_fix = neg_q ? -acc_nxt : acc_nxt;
        quo      = neg_q ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
        rem      = neg_q ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:                     result = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:            result = quo;
            default:                    result = rem;
        endcase
    end

    assign done = busy_q && (cnt_q == CNT_W'(XLEN - 1));

    // ---- control stage ----
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
        end else if (busy_q) begin
            cnt_q <= cnt_q + 1'b1;
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

    // ---- datapath stage ----
    always_ff @(posedge clk) begin
        if (start) begin
            op_q    <= op;
            neg_q   <= is_divrem(op) && (op == OP_REM || op == OP_REMU) ? a_neg : (a_neg ^ b_neg);
            mcand_q <= b_mag;
            acc_q   <= {{XLEN{1'b0}}, a_mag};
        end else if (busy_q) begin
            acc_q <= acc_nxt;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
// RV32IM ALU decode-and-execute unit. Base ops complete in one cycle,
// mul/div/rem run on alu_iter_muldiv for XLEN cycles.
//   clk, rst, flush         : clock, synchronous active-high reset, abort
//   in_valid / in_ready     : request handshake
//   alu_op, instruction     : decode inputs (funct3, funct7, bit 30 used)
//   op_a, op_b              : rs1 and rs2/immediate
//   out_valid / out_ready   : result handshake
//   result, zero, illegal   : registered result, result==0, no legal decode
// ---------------------------------------------------------------------------
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);
    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    state_e                 state_q;
    logic                   vld_p1;
    logic [XLEN-1:0]        res_p1;
    logic                   zero_p1;
    logic                   illegal_p1;

    alu_op_e                op_p0;
    logic [XLEN-1:0]        res_p0;
    logic                   accept_p0;
    logic                   special_p0;
    logic                   iter_start_p0;
    logic                   div_zero;
    logic                   div_ovf;
    logic [2:0]             funct3;
    logic [6:0]             funct7;
    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;
    logic [SHAMT_W-1:0]     shamt;

    logic                   eng_done;
    logic [XLEN-1:0]        eng_result;
    logic                   unused_instr;

    assign unused_instr = ^{instruction[24:15], instruction[11:0]};

    assign funct3 = instruction[14:12];
    assign funct7 = instruction[31:25];
    assign a_s    = op_a;
    assign b_s    = op_b;
    assign shamt  = op_b[SHAMT_W-1:0];

    // Fixed results for the divide corner cases that bypass the engine.
    // Only called when the op is div-class and (div_z || signed overflow).
    function automatic logic [XLEN-1:0] special_result(input alu_op_e op,
                                                       input logic [XLEN-1:0] a,
                                                       input logic div_z);
        if (op == OP_DIV || op == OP_DIVU) begin
            return div_z ? {XLEN{1'b1}} : a;
        end
        return div_z ? a : {XLEN{1'b0}};
    endfunction

    // ---- decode stage (p0) ----
    always_comb begin
        op_p0 = OP_ILLEGAL;
        case (alu_op)
            ALUOP_ADD: op_p0 = OP_ADD;
            ALUOP_SUB: op_p0 = OP_SUB;
            ALUOP_ITYPE: begin
                case (funct3)
                    F3_ADD_SUB: op_p0 = OP_ADD;
                    F3_SLL:     op_p0 = OP_SLL;
                    F3_SLT:     op_p0 = OP_SLT;
                    F3_SLTU:    op_p0 = OP_SLTU;
                    F3_XOR:     op_p0 = OP_XOR;
                    F3_SRL_SRA: op_p0 = instruction[30] ? OP_SRA : OP_SRL;
                    F3_OR:      op_p0 = OP_OR;
                    default:    op_p0 = OP_AND;
                endcase
            end
            default: begin
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        F3_ADD_SUB: op_p0 = OP_ADD;
                        F3_SLL:     op_p0 = OP_SLL;
                        F3_SLT:     op_p0 = OP_SLT;
                        F3_SLTU:    op_p0 = OP_SLTU;
                        F3_XOR:     op_p0 = OP_XOR;
                        F3_SRL_SRA: op_p0 = OP_SRL;
                        F3_OR:      op_p0 = OP_OR;
                        default:    op_p0 = OP_AND;
                    endcase
                end else if (funct7 == F7_ALT) begin
                    if (funct3 == F3_ADD_SUB) begin
                        op_p0 = OP_SUB;
                    end else if (funct3 == F3_SRL_SRA) begin
                        op_p0 = OP_SRA;
                    end
                end else if (funct7 == F7_MULDIV) begin
                    case (funct3)
                        F3_MUL:    op_p0 = OP_MUL;
                        F3_MULH:   op_p0 = OP_MULH;
                        F3_MULHSU: op_p0 = OP_MULHSU;
                        F3_MULHU:  op_p0 = OP_MULHU;
                        F3_DIV:    op_p0 = OP_DIV;
                        F3_DIVU:   op_p0 = OP_DIVU;
                        F3_REM:    op_p0 = OP_REM;
                        default:   op_p0 = OP_REMU;
                    endcase
                end
            end
        endcase
    end

    always_comb begin
        div_zero   = (op_b == '0);
        div_ovf    = (op_p0 == OP_DIV || op_p0 == OP_REM) && (op_a == XMIN) && (op_b == '1);
        special_p0 = is_divrem(op_p0) && (div_zero || div_ovf);
    end

    // Single-cycle datapath; mul/div entries are only used for special cases.
    always_comb begin
        res_p0 = '0;
        case (op_p0)
            OP_ADD:  res_p0 = op_a + op_b;
            OP_SUB:  res_p0 = op_a - op_b;
            OP_SLL:  res_p0 = op_a << shamt;
            OP_SLT:  res_p0 = {{(XLEN-1){1'b0}}, a_s < b_s};
            OP_SLTU: res_p0 = {{(XLEN-1){1'b0}}, op_a < op_b};
            OP_XOR:  res_p0 = op_a ^ op_b;
            OP_SRL:  res_p0 = op_a >> shamt;
            OP_SRA:  res_p0 = $unsigned(a_s >>> shamt);
            OP_OR:   res_p0 = op_a | op_b;
            OP_AND:  res_p0 = op_a & op_b;
            OP_DIV, OP_DIVU, OP_REM, OP_REMU:
                     res_p0 = special_result(op_p0, op_a, div_zero);
            default: res_p0 = '0;
        endcase
    end

    assign in_ready      = !rst && !flush && (state_q == IDLE) && (!vld_p1 || out_ready);
    assign accept_p0     = in_valid && in_ready;
    assign iter_start_p0 = accept_p0 && is_muldiv(op_p0) && !special_p0;

    alu_iter_muldiv #(
        .XLEN (XLEN)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .start  (iter_start_p0),
        .op     (op_p0),
        .a      (op_a),
        .b      (op_b),
        .done   (eng_done),
        .result (eng_result)
    );

    // ---- output register stage (p1) ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            vld_p1     <= 1'b0;
            res_p1     <= '0;
            zero_p1    <= 1'b0;
            illegal_p1 <= 1'b0;
        end else if (flush) begin
            state_q <= IDLE;
            vld_p1  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (iter_start_p0) begin
                        state_q <= BUSY;
                        vld_p1  <= 1'b0;
                    end else if (accept_p0) begin
                        vld_p1     <= 1'b1;
                        res_p1     <= res_p0;
                        zero_p1    <= (res_p0 == '0);
                        illegal_p1 <= (op_p0 == OP_ILLEGAL);
                    end else if (vld_p1 && out_ready) begin
                        vld_p1 <= 1'b0;
                    end
                end
                default: begin
                    if (eng_done) begin
                        state_q    <= IDLE;
                        vld_p1     <= 1'b1;
                        res_p1     <= eng_result;
                        zero_p1    <= (eng_result == '0);
                        illegal_p1 <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign out_valid = vld_p1;
    assign result    = res_p1;
    assign zero      = zero_p1;
    assign illegal   = illegal_p1;

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised ALU decode-and-execute unit for the RV32IM core. It replaces the purely combinational control-signal decoder with a block that decodes `alu_op` and the instruction fields and executes the operation. Base-ISA ops complete in one cycle. M-extension multiply, divide and remainder run on an iterative engine. It sits between the register-read stage and writeback, with valid/ready handshakes on both sides.

## Interface
Parameters:
- `XLEN`, default 32: operand and result width. Must be a power of two, at least 8.
- `SHAMT_W`, default $clog2(XLEN): shift-amount width.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `flush` in 1: abort any in-flight op and drop the output register.
- `in_valid` in 1: request present.
- `in_ready` out 1: unit can accept a request this cycle.
- `alu_op` in 2: from main control.
  - 00: add (load/store address).
  - 01: sub (branch compare).
  - 10: I-type.
  - 11: R-type.
- `instruction` in 32: full instruction word. Bits [14:12], [31:25] and [30] are used.
- `op_a` in XLEN: rs1 value.
- `op_b` in XLEN: rs2 value or immediate.
- `out_valid` out 1: `result` is valid.
- `out_ready` in 1: consumer takes the result.
- `result` out XLEN: operation result.
- `zero` out 1: asserted when `result` is 0.
- `illegal` out 1: the decode had no legal mapping.

## Operation
- Decode, `alu_op` 10 (I-type), selected by funct3:
  - 000 addi; 010 slti; 011 sltiu; 100 xori; 110 ori; 111 andi.
  - 001 slli; 101 srli when instr[30]=0, srai when instr[30]=1.
- Decode, `alu_op` 11 (R-type), funct7=0000000: add, sll, slt, sltu, xor, srl, or, and.
- Decode, `alu_op` 11, funct7=0100000: sub (funct3 000) and sra (funct3 101) only.
- Decode, `alu_op` 11, funct7=0000001: mul, mulh, mulhsu, mulhu, div, divu, rem, remu, by funct3 000 through 111.
- Illegal decode: any other funct7/funct3 combination.
  - Completes as a single-cycle op with `result`=0 and `illegal`=1.
- Shifts use `op_b[SHAMT_W-1:0]`. slt and sltu produce 0 or 1, zero-extended.
- States:
  - IDLE to BUSY: accept of a mul or div op that is not a special case.
  - BUSY to IDLE: after XLEN iterations.
- Multiply:
  - Radix-2 shift-add on magnitudes, 2*XLEN-bit accumulator.
  - Sign fix-up is applied on the final load.
  - mul returns the low XLEN bits. mulh, mulhsu and mulhu return the high XLEN bits.
- Divide:
  - Restoring division on magnitudes.
  - Quotient sign is a XOR b. Remainder sign follows the dividend.
- Special cases skip BUSY and complete as single-cycle ops:
  - Divide by zero: quotient = all ones, remainder = `op_a`.
  - Signed overflow (-2^(XLEN-1) / -1): quotient = `op_a`, remainder = 0.
- Output register:
  - Holds `result`, `zero` and `illegal` until `out_valid && out_ready`.
  - These outputs are stable while `out_valid=1` and `out_ready=0`.
- Flush:
  - Forces IDLE, clears the iteration counter and clears `out_valid`.
  - No result is produced for the aborted op.
  - `in_ready` is 0 during the flush cycle.

## Timing
- Reset values:
  - `out_valid`=0, `result`=0, `zero`=0, `illegal`=0.
  - State IDLE, counter 0.
  - `in_ready`=0 while `rst`=1.
- `in_ready` = !rst && !flush && state==IDLE && (!out_valid || out_ready). Combinational, with no dependence on `in_valid`.
- Accept occurs on an edge where `in_valid && in_ready`. Inputs are sampled only at that edge and may change afterwards.
- Single-cycle ops (including special cases and illegal): accepted at edge N, `out_valid`=1 after edge N.
- Iterative ops:
  - Accepted at edge N, then BUSY for XLEN edges.
  - `out_valid` rises after edge N+XLEN.
  - `in_ready`=0 throughout BUSY.
- Back-to-back single-cycle ops with `out_ready` held at 1 give a throughput of 1 per cycle.
- Priority when events coincide: `rst` > `flush` > completion/accept.
  - A `rst` or `flush` in the same cycle as completion discards the result.
- Reset asserted mid-BUSY: the unit is in IDLE with outputs at reset values on the next cycle.

## Structure
- Package `alu_pkg` holds:
  - `alu_op_e`: 5-bit enum of 18 ops plus ILLEGAL.
  - Localparams for funct3 codes, funct7 codes (F7_BASE, F7_ALT, F7_MULDIV) and `alu_op` codes.
  - State enum IDLE/BUSY.
- Sub-module `alu_iter_muldiv` holds:
  - The XLEN-iteration mul/div engine: counter, accumulator, magnitude/sign logic.
  - Ports: start, op, a, b, done, result.
- The top level holds the decoder, single-cycle datapath, special-case detection, FSM and output register.

## Test plan
- Handshake and single-cycle ops (XLEN=32):
  - `alu_op`=11 add with a=5, b=-7 -> `result`=0xFFFFFFFE after 1 cycle.
  - `alu_op`=10 srai with a=0x80000000, shamt 4 -> 0xF8000000.
  - `alu_op`=01 with a=b=9 -> `result`=0, `zero`=1.
  - Back-to-back adds give throughput 1/cycle.
- Multiply:
  - mulh with a=0x80000000, b=2 -> 0xFFFFFFFF.
  - mulhu with a=b=0xFFFFFFFF -> 0xFFFFFFFE.
  - `out_valid` exactly 32 cycles after accept; `in_ready`=0 meanwhile.
- Divide:
  - div -7/2 -> 0xFFFFFFFD. rem -7/2 -> 0xFFFFFFFF.
  - divu 7/0 -> 0xFFFFFFFF. remu 7/0 -> 7.
  - div 0x80000000/-1 -> 0x80000000 at 1-cycle latency.
- Backpressure: hold `out_ready`=0 for 5 cycles after a result.
  - `result` stays stable and `in_ready`=0.
  - Releasing `out_ready` allows an accept in the same cycle.
- Flush and reset:
  - `flush` at BUSY cycle 10 -> no `out_valid`; the next op is accepted the cycle after.
  - `rst` mid-BUSY -> all outputs at reset values.
- Illegal decode: funct7=0100000 with funct3=110 -> `illegal`=1 and `result`=0 after 1 cycle.
- Parameter sweep: repeat the multiply and divide cases at XLEN=8 and XLEN=64.
  - Iterative latency equals XLEN.
